// File: rtl/npu_stream_pkg.sv
// Types and defaults shared by the systolic-array stream blocks (skewer, deskewer, ...).
package npu_stream_pkg;
  typedef enum logic {DSK_IDLE, DSK_STREAM} deskew_state_t;
  localparam int DSK_CNT_W = 16;
endpackage

// File: rtl/shift_delay.sv
// Fixed-depth enabled delay line; q is d delayed by DEPTH enabled cycles.
module shift_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/streaming_deskewer.sv
// Realigns skewed systolic-array output lanes into whole vectors and frames them.
// Optional macro DESKEW_PROTO_CHECK_EN enables the sticky proto_err check.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module streaming_deskewer import npu_stream_pkg::*; #(
  parameter int N          = `ARRAY_SIZE,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = DSK_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   data_in [N-1:0],
  input  logic                    first_in,
  input  logic                    last_in,
  output logic [DATA_WIDTH-1:0]   data_out [N-1:0],
  output logic [N*DATA_WIDTH-1:0] data_out_flat,
  output logic                    valid_out,
  output logic                    first_out,
  output logic                    last_out,
  output logic [CNT_WIDTH-1:0]    vec_count,
  output logic                    proto_err
);
  deskew_state_t state;
  logic          first_q, last_q;

  // Lane j lags lane 0 by j cycles, so it needs N-j stages to catch up.
  for (genvar j = 0; j < N; j++) begin : g_lane
    shift_delay #(.WIDTH(DATA_WIDTH), .DEPTH(N-j)) u_lane (
      .clk(clk), .rst(rst), .en(en), .d(data_in[j]), .q(data_out[j])
    );
    assign data_out_flat[j*DATA_WIDTH +: DATA_WIDTH] = data_out[j];
  end

  shift_delay #(.WIDTH(1), .DEPTH(N)) u_first (
    .clk(clk), .rst(rst), .en(en), .d(first_in), .q(first_q)
  );
  shift_delay #(.WIDTH(1), .DEPTH(1)) u_last (
    .clk(clk), .rst(rst), .en(en), .d(last_in), .q(last_q)
  );

  assign first_out = en & first_q;
  assign last_out  = en & last_q;
  assign valid_out = en & ((state == DSK_STREAM) | first_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DSK_IDLE;
      vec_count <= '0;
    end else if (en) begin
      case (state)
        DSK_IDLE:   if (first_out && !last_out) state <= DSK_STREAM;
        DSK_STREAM: if (last_out) state <= DSK_IDLE;
        default:    state <= DSK_IDLE;
      endcase
      if (first_out)
        vec_count <= CNT_WIDTH'(1);
      else if (valid_out && !(&vec_count))
        vec_count <= vec_count + CNT_WIDTH'(1);
    end
  end

`ifdef DESKEW_PROTO_CHECK_EN
  logic err_hit, err_q;
  assign err_hit = (first_out && state == DSK_STREAM && !last_out) ||
                   (last_out && state == DSK_IDLE && !first_out) ||
                   (valid_out && !first_out && (&vec_count));

  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  // Flag in the offending cycle itself, then hold until reset.
  assign proto_err = err_q | err_hit;
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_streaming_deskewer.sv
// Scoreboard bench for streaming_deskewer (N=4, 8-bit lanes, default build).
module tb_streaming_deskewer;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, en, first_in, last_in;
  logic [W-1:0]  data_in  [N-1:0];
  logic [W-1:0]  data_out [N-1:0];
  logic [N*W-1:0] data_out_flat;
  logic          valid_out, first_out, last_out, proto_err;
  logic [CW-1:0] vec_count;

  streaming_deskewer #(.N(N), .DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .first_in(first_in), .last_in(last_in),
    .data_out(data_out), .data_out_flat(data_out_flat),
    .valid_out(valid_out), .first_out(first_out), .last_out(last_out),
    .vec_count(vec_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [N*W-1:0] d; bit first; bit last;} slot_t;
  typedef struct {logic [N*W-1:0] d; bit first; bit last; int cnt;} exp_t;

  slot_t sched[$];
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    total = 0, passed = 0;
  int    model_cnt = 0;
  bit    cnt_pend = 0;
  int    cnt_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, want);
  endtask

  // Count register updates at the edge closing a valid cycle, so it is checked one cycle later.
  always @(negedge clk) begin
    if (rst) cnt_pend = 0;
    else begin
      if (cnt_pend) begin
        check("vec_count", vec_count, cnt_exp);
        cnt_pend = 0;
      end
      if (valid_out) begin
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("data_flat", data_out_flat, mon_e.d);
          check("data_lane3", data_out[3], mon_e.d[31:24]);
          check("first_out", first_out, mon_e.first);
          check("last_out", last_out, mon_e.last);
          check("proto_err", proto_err, 0);
          cnt_exp  = mon_e.cnt;
          cnt_pend = 1;
        end
      end else if (first_out || last_out) begin
        check("marker_without_valid", 1, 0);
      end
    end
  end

  task automatic drive_idle();
    for (int j = 0; j < N; j++) data_in[j] = '0;
    first_in = 0;
    last_in  = 0;
  endtask

  // Feed sched skewed: lane j of slot k enters at cycle k+j.
  task automatic play(input int stall_at, input int abort_at);
    int n;
    n = sched.size();
    for (int c = 0; c < n + N + 1; c++) begin
      if (c == abort_at) begin
        drive_idle();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_q.delete();
        sched.delete();
        check("abort_flat", data_out_flat, 0);
        check("abort_valid", valid_out, 0);
        check("abort_first", first_out, 0);
        check("abort_last", last_out, 0);
        check("abort_count", vec_count, 0);
        repeat (N + 2) begin @(posedge clk); #1; end
        check("abort_quiet_valid", valid_out, 0);
        model_cnt = 0;
        return;
      end
      if (c == stall_at) begin
        en = 0;
        repeat (2) begin
          @(negedge clk);
          check("stall_valid", valid_out, 0);
          check("stall_first", first_out, 0);
          check("stall_last", last_out, 0);
          if (exp_q.size() > 0) check("stall_data", data_out_flat, exp_q[0].d);
          else check("stall_pending", 0, 1);
          @(posedge clk); #1;
        end
        en = 1;
      end
      for (int j = 0; j < N; j++) begin
        data_in[j] = '0;
        if (c - j >= 0 && c - j < n) data_in[j] = sched[c-j].d[j*W +: W];
      end
      first_in = 0;
      last_in  = 0;
      if (c < n) begin
        first_in  = sched[c].first;
        model_cnt = sched[c].first ? 1 : model_cnt + 1;
        exp_q.push_back('{sched[c].d, sched[c].first, sched[c].last, model_cnt});
      end
      if (c - (N-1) >= 0 && c - (N-1) < n) last_in = sched[c-(N-1)].last;
      @(posedge clk); #1;
    end
    drive_idle();
    sched.delete();
    check("drained", exp_q.size(), 0);
    check("count_hold", vec_count, model_cnt);
  endtask

  initial begin
    rst = 1; en = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_flat", data_out_flat, 0);
    check("rst_valid", valid_out, 0);
    check("rst_count", vec_count, 0);
    check("rst_proto_err", proto_err, 0);
    rst = 0; en = 1;

    // single-vector stream: first and last on the same output cycle
    sched.push_back('{32'h44332211, 1'b1, 1'b1});
    play(-1, -1);

    // three-vector stream, continuous enable
    sched.push_back('{32'hA3A2A1A0, 1'b1, 1'b0});
    sched.push_back('{32'hB3B2B1B0, 1'b0, 1'b0});
    sched.push_back('{32'hC3C2C1C0, 1'b0, 1'b1});
    play(-1, -1);

    // same shape with a two-cycle stall once output has started
    sched.push_back('{32'h13121110, 1'b1, 1'b0});
    sched.push_back('{32'h23222120, 1'b0, 1'b0});
    sched.push_back('{32'h33323130, 1'b0, 1'b1});
    play(5, -1);

    // reset with two vectors in flight
    sched.push_back('{32'h5A5B5C5D, 1'b1, 1'b0});
    sched.push_back('{32'h6A6B6C6D, 1'b0, 1'b0});
    sched.push_back('{32'h7A7B7C7D, 1'b0, 1'b1});
    play(-1, 2);
    check("post_abort_proto_err", proto_err, 0);

    // back-to-back: A (2 vectors) then B (1 vector), no gap
    sched.push_back('{32'hDEADBEEF, 1'b1, 1'b0});
    sched.push_back('{32'hCAFEF00D, 1'b0, 1'b1});
    sched.push_back('{32'h01234567, 1'b1, 1'b1});
    play(-1, -1);
    check("b2b_proto_err", proto_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/streaming_deskewer.md
Name: streaming_deskewer

Overview:
Inverse of the input skewer. Sits on the systolic array's output edge. Lane j of the array output arrives j cycles after lane 0 of the same result vector. This block delays each lane so that all N lanes of a vector emerge on the same cycle. It also realigns the first/last markers and frames the aligned stream with a valid signal and a vector count for the writeback path.

Parameters:
- N, `ARRAY_SIZE, number of lanes (array columns); generic, built with a generate loop, N >= 2.
- DATA_WIDTH, `DATA_WIDTH, lane width; instantiated with accumulator width at the array output.
- CNT_WIDTH, 16, width of the vector counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  global advance; all state holds when low.
- data_in  input  [DATA_WIDTH-1:0] x N (unpacked [N-1:0])  skewed lane data; lane j lags lane 0 by j cycles.
- first_in  input  1  pulse coincident with lane-0 element of the first vector of a stream.
- last_in  input  1  pulse coincident with lane-(N-1) element of the last vector of a stream.
- data_out  output  [DATA_WIDTH-1:0] x N  aligned vector.
- data_out_flat  output  N*DATA_WIDTH  {data_out[N-1],...,data_out[0]} for Verilator.
- valid_out  output  1  data_out holds a vector of the current stream.
- first_out  output  1  aligned first marker.
- last_out  output  1  aligned last marker.
- vec_count  output  CNT_WIDTH  vectors emitted in current/most recent stream.
- proto_err  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Lane j passes through N-j register stages: lane 0 has N stages, lane N-1 has 1. Stages advance only when en=1.
- Vector whose lane 0 enters at cycle t appears complete on data_out at cycle t+N (counted in en-cycles).
- first_in rides lane 0's chain (N stages). last_in rides lane N-1's chain (1 stage). Both markers then align with their vector on data_out.
- first_out and last_out are the chain outputs gated with en; each is a 1-cycle pulse per en-cycle.
- FSM (registered state): IDLE, STREAM.
  - IDLE: first_out & !last_out -> STREAM.
  - IDLE: first_out & last_out (single-vector stream) -> stay IDLE.
  - STREAM: last_out -> IDLE.
  - STREAM: a first_out without last_out stays STREAM (error case).
- valid_out = en & ((state==STREAM) | first_out). It is combinational from registered state and chain outputs. It is high from first_out through last_out inclusive.
- vec_count:
  - Loads 1 on a first_out cycle (en=1).
  - Increments on each other valid_out cycle.
  - Saturates at all-ones.
  - Holds its value after the stream ends until the next first_out.
- en=0: all chains, state and vec_count hold; valid_out, first_out and last_out are 0.
- Reset: all chain registers, state=IDLE, vec_count=0 and proto_err=0.
  - Resulting outputs: data_out all 0, flat 0, valid/first/last 0.
  - Reset mid-stream discards in-flight data; no marker is emitted afterwards for it.
- Back-to-back streams: last_out of stream A and first_out of stream B on consecutive cycles are legal. A last_out and a new first_out in the same cycle (while in STREAM) end A; B is then treated per the error rule.

Optional Feature:
- Macro DESKEW_PROTO_CHECK_EN.
- Defined: proto_err is set, and stays set until rst, on any of:
  - first_out while state==STREAM and not last_out;
  - last_out while state==IDLE and not first_out;
  - vec_count saturation.
- Undefined: no check logic; proto_err tied to 0. The port is always present.

Decomposition:
- Package npu_stream_pkg holds:
  - deskew_state_t enum {DSK_IDLE, DSK_STREAM};
  - localparam DSK_CNT_W default.
  - The skewer and future stream blocks share this package.
- One natural sub-module: shift_delay #(WIDTH, DEPTH) with clk, rst, en, d, q. It is instantiated per lane and per marker chain with DEPTH>=1.

Test Plan (N=4, DATA_WIDTH=8):
- Single vector: lanes fed skewed with 0x11/0x22/0x33/0x44 at t0..t3, first_in@t0, last_in@t3 -> data_out={44,33,22,11}, valid/first/last all high at t4 only; vec_count=1; state stays IDLE.
- Stream of 3 vectors, continuous en -> valid_out high 3 consecutive cycles starting t4, first_out on cycle 1, last_out on cycle 3; vec_count 1,2,3.
- en held low 2 cycles mid-stream -> outputs freeze, valid_out=0 during stall, aligned data resumes unchanged; total latency 4 en-cycles.
- rst asserted mid-stream (after 2 vectors in flight) -> next cycle all outputs 0 and IDLE; no last_out ever emitted for the aborted stream.
- Back-to-back streams A(2 vectors), B(1 vector) with no gap -> last_out(A) at c, first_out(B) at c+1; vec_count 2 then reloads 1; proto_err=0.
- With DESKEW_PROTO_CHECK_EN: last_in with no preceding stream -> proto_err=1 from the last_out cycle and held until rst; without the macro proto_err stays 0.
